// File: rtl/robo_controller.sv
// -----------------------------------------------------------------------------
// robo_controller
//
// Autonomous navigation controller for the cleaning robot. It reads the map
// block's sensor outputs and drives the map's command inputs. It runs a
// left-hand wall follower with a barrier-removal sub-sequence, and halts once
// the robot stands on the black target cell.
//
// Ports
//   Clock50     in   controller clock (the map's ClockRobo)
//   Reset       in   asynchronous active-low reset
//   enable      in   run permission; 0 freezes the FSM where it is
//   head_in     in   wall ahead
//   left_in     in   wall on the left
//   under_in    in   robot is on the black cell
//   barrier_in  in   removable trash ahead
//   avancar     out  one-cycle advance command
//   girar       out  one-cycle 90 degree CCW turn command
//   remover     out  removal command, held while the barrier is present
//   done        out  target reached
//   state_out   out  current FSM state, for LEDs
//   steps       out  saturating count of advance pulses issued
// -----------------------------------------------------------------------------
module robo_controller #(
  parameter int SETTLE_CYCLES  = 1,
  parameter int REMOVE_TIMEOUT = 15,
  parameter int STEP_WIDTH     = 16
) (
  input  logic                  Clock50,
  input  logic                  Reset,
  input  logic                  enable,
  input  logic                  head_in,
  input  logic                  left_in,
  input  logic                  under_in,
  input  logic                  barrier_in,
  output logic                  avancar,
  output logic                  girar,
  output logic                  remover,
  output logic                  done,
  output logic [2:0]            state_out,
  output logic [STEP_WIDTH-1:0] steps
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] DECIDE  = 3'd1;
  localparam logic [2:0] ADVANCE = 3'd2;
  localparam logic [2:0] TURN_L  = 3'd3;
  localparam logic [2:0] TURN_R  = 3'd4;
  localparam logic [2:0] SETTLE  = 3'd5;
  localparam logic [2:0] REMOVE  = 3'd6;
  localparam logic [2:0] DONE    = 3'd7;

  localparam int CW = 16;
  // SETTLE always lasts at least one cycle, even if SETTLE_CYCLES is 0.
  localparam logic [CW-1:0] SETTLE_LAST = CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [CW-1:0] RM_LAST     = CW'((REMOVE_TIMEOUT > 0) ? REMOVE_TIMEOUT - 1 : 0);
  localparam logic [STEP_WIDTH-1:0] STEPS_MAX = {STEP_WIDTH{1'b1}};

  logic [2:0]            state_q,     state_d;
  logic                  avancar_q,   avancar_d;
  logic                  girar_q,     girar_d;
  logic                  done_q,      done_d;
  logic [STEP_WIDTH-1:0] steps_q,     steps_d;
  logic [1:0]            turn_cnt_q,  turn_cnt_d;
  logic [CW-1:0]         settle_q,    settle_d;
  logic [CW-1:0]         rm_timer_q,  rm_timer_d;
  logic                  last_left_q, last_left_d;
  logic                  rm_fail_q,   rm_fail_d;

  // A timed-out barrier is masked until the robot moves or turns, so the
  // FSM cannot loop forever on a barrier it failed to remove.
  logic barrier_eff;
  assign barrier_eff = barrier_in & ~rm_fail_q;

  always_comb begin
    state_d     = state_q;
    avancar_d   = avancar_q;
    girar_d     = girar_q;
    done_d      = done_q;
    steps_d     = steps_q;
    turn_cnt_d  = turn_cnt_q;
    settle_d    = settle_q;
    rm_timer_d  = rm_timer_q;
    last_left_d = last_left_q;
    rm_fail_d   = rm_fail_q;

    case (state_q)
      IDLE: begin
        if (enable) state_d = DECIDE;
      end

      DECIDE: begin
        if (enable) begin
          if (under_in) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (barrier_eff) begin
            state_d    = REMOVE;
            rm_timer_d = '0;
          end else if (!left_in && !last_left_q) begin
            state_d     = TURN_L;
            girar_d     = 1'b1;
            last_left_d = 1'b1;
            rm_fail_d   = 1'b0;
          end else if (!head_in) begin
            state_d     = ADVANCE;
            avancar_d   = 1'b1;
            last_left_d = 1'b0;
            rm_fail_d   = 1'b0;
            if (steps_q != STEPS_MAX) steps_d = steps_q + STEP_WIDTH'(1);
          end else begin
            state_d    = TURN_R;
            girar_d    = 1'b1;
            turn_cnt_d = 2'd1;
            rm_fail_d  = 1'b0;
          end
        end
      end

      ADVANCE: begin
        if (enable) begin
          avancar_d = 1'b0;
          settle_d  = '0;
          state_d   = SETTLE;
        end
      end

      TURN_L: begin
        if (enable) begin
          girar_d  = 1'b0;
          settle_d = '0;
          state_d  = SETTLE;
        end
      end

      // Three pulses with a low cycle between each: 1,0,1,0,1.
      // turn_cnt_q holds the number of pulses already issued.
      TURN_R: begin
        if (enable) begin
          if (girar_q) begin
            girar_d = 1'b0;
            if (turn_cnt_q == 2'd3) begin
              turn_cnt_d = 2'd0;
              settle_d   = '0;
              state_d    = SETTLE;
            end
          end else begin
            girar_d    = 1'b1;
            turn_cnt_d = turn_cnt_q + 2'd1;
          end
        end
      end

      SETTLE: begin
        if (enable) begin
          if (settle_q >= SETTLE_LAST) begin
            settle_d = '0;
            state_d  = DECIDE;
          end else begin
            settle_d = settle_q + CW'(1);
          end
        end
      end

      REMOVE: begin
        if (enable) begin
          if (!barrier_in || (rm_timer_q == RM_LAST)) begin
            // Leaving with the barrier still present means the timer expired.
            if (barrier_in) rm_fail_d = 1'b1;
            rm_timer_d = '0;
            settle_d   = '0;
            state_d    = SETTLE;
          end else begin
            rm_timer_d = rm_timer_q + CW'(1);
          end
        end
      end

      DONE: begin
        state_d = DONE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock50 or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      avancar_q   <= 1'b0;
      girar_q     <= 1'b0;
      done_q      <= 1'b0;
      steps_q     <= '0;
      turn_cnt_q  <= 2'd0;
      settle_q    <= '0;
      rm_timer_q  <= '0;
      last_left_q <= 1'b0;
      rm_fail_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      avancar_q   <= avancar_d;
      girar_q     <= girar_d;
      done_q      <= done_d;
      steps_q     <= steps_d;
      turn_cnt_q  <= turn_cnt_d;
      settle_q    <= settle_d;
      rm_timer_q  <= rm_timer_d;
      last_left_q <= last_left_d;
      rm_fail_q   <= rm_fail_d;
    end
  end

  // Commands are gated by enable so a pause silences a pending pulse without
  // losing it; the pulse reappears when enable returns.
  assign avancar   = avancar_q & enable;
  assign girar     = girar_q & enable;
  // Combinational so remover falls in the very cycle the barrier disappears.
  assign remover   = (state_q == REMOVE) & barrier_in & enable;
  assign done      = done_q;
  assign state_out = state_q;
  assign steps     = steps_q;

endmodule

// File: tb/tb_robo_controller.sv
module tb_robo_controller;

  logic        Clock50;
  logic        Reset;
  logic        enable;
  logic        head_in;
  logic        left_in;
  logic        under_in;
  logic        barrier_in;
  logic        avancar;
  logic        girar;
  logic        remover;
  logic        done;
  logic [2:0]  state_out;
  logic [15:0] steps;

  int checks = 0;
  int errors = 0;

  robo_controller #(
    .SETTLE_CYCLES (1),
    .REMOVE_TIMEOUT(15),
    .STEP_WIDTH    (16)
  ) dut (
    .Clock50   (Clock50),
    .Reset     (Reset),
    .enable    (enable),
    .head_in   (head_in),
    .left_in   (left_in),
    .under_in  (under_in),
    .barrier_in(barrier_in),
    .avancar   (avancar),
    .girar     (girar),
    .remover   (remover),
    .done      (done),
    .state_out (state_out),
    .steps     (steps)
  );

  initial Clock50 = 1'b0;
  always #5 Clock50 = ~Clock50;

  // All sampling and driving happens on the falling edge.
  task automatic step();
    @(negedge Clock50);
  endtask

  // Advance falling edges until state_out equals s; an expired budget counts
  // as a failed comparison.
  task automatic wait_state(input logic [2:0] s, input int budget);
    int n;
    n = 0;
    while (state_out !== s && n < budget) begin
      step();
      n++;
    end
    if (state_out !== s) begin
      checks++;
      errors++;
      $display("FAIL wait_state: state_out=%0d, required %0d within %0d cycles", state_out, s, budget);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0; enable = 1'b1;
    head_in = 1'b0; left_in = 1'b1; under_in = 1'b0; barrier_in = 1'b0;
    step(); step();
    checks++;
    if ({state_out, avancar, girar, remover, done} !== 7'b000_0000) begin
      errors++;
      $display("FAIL reset_outputs: state=%0d av=%b gi=%b rm=%b dn=%b, required all 0", state_out, avancar, girar, remover, done);
    end
    checks++;
    if (steps !== 16'd0) begin errors++; $display("FAIL reset_steps: got %0d, required 0", steps); end
    $display("reset: state=%0d steps=%0d", state_out, steps);
  endtask

  task automatic test_advance();
    Reset = 1'b1;
    step();
    checks++;
    if (state_out !== 3'd1 || avancar !== 1'b0) begin
      errors++; $display("FAIL adv_decide: state=%0d av=%b, required 1/0", state_out, avancar);
    end
    step();
    checks++;
    if (state_out !== 3'd2 || avancar !== 1'b1 || girar !== 1'b0 || steps !== 16'd1) begin
      errors++; $display("FAIL adv_pulse: state=%0d av=%b gi=%b steps=%0d, required 2/1/0/1", state_out, avancar, girar, steps);
    end
    step();
    checks++;
    if (state_out !== 3'd5 || avancar !== 1'b0) begin
      errors++; $display("FAIL adv_settle: state=%0d av=%b, required 5/0", state_out, avancar);
    end
    step();
    checks++;
    if (state_out !== 3'd1) begin errors++; $display("FAIL adv_redecide: state=%0d, required 1", state_out); end
    $display("advance: steps=%0d state=%0d", steps, state_out);
  endtask

  task automatic test_turn_left();
    // Currently in DECIDE; these sensors are sampled on the next edge.
    left_in = 1'b0; head_in = 1'b0;
    step();
    checks++;
    if (state_out !== 3'd3 || girar !== 1'b1 || avancar !== 1'b0) begin
      errors++; $display("FAIL tl_pulse: state=%0d gi=%b av=%b, required 3/1/0", state_out, girar, avancar);
    end
    step();
    checks++;
    if (state_out !== 3'd5 || girar !== 1'b0) begin
      errors++; $display("FAIL tl_settle: state=%0d gi=%b, required 5/0", state_out, girar);
    end
    step(); // DECIDE with left still open
    step();
    checks++;
    if (state_out !== 3'd2 || avancar !== 1'b1 || girar !== 1'b0 || steps !== 16'd2) begin
      errors++; $display("FAIL tl_forced_adv: state=%0d av=%b gi=%b steps=%0d, required 2/1/0/2", state_out, avancar, girar, steps);
    end
    $display("turn_left: steps=%0d", steps);
  endtask

  task automatic test_turn_right();
    logic [4:0] pat;
    int bad;
    pat = 5'b10101;
    bad = 0;
    head_in = 1'b1; left_in = 1'b1;
    wait_state(3'd1, 10);
    for (int i = 0; i < 5; i++) begin
      step();
      if (state_out !== 3'd4 || girar !== pat[4-i] || avancar !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL tr_pattern: %0d bad cycles, required 0", bad); end
    step();
    checks++;
    if (state_out !== 3'd5 || girar !== 1'b0) begin
      errors++; $display("FAIL tr_settle: state=%0d gi=%b, required 5/0", state_out, girar);
    end
    $display("turn_right: pattern checked, state=%0d", state_out);
  endtask

  task automatic test_remove_short();
    int hi;
    hi = 0;
    barrier_in = 1'b1;
    wait_state(3'd1, 10);
    for (int i = 0; i < 6; i++) begin
      step();
      if (state_out === 3'd6 && remover === 1'b1) hi++;
    end
    checks++;
    if (hi != 6) begin errors++; $display("FAIL rm_short_high: %0d cycles, required 6", hi); end
    barrier_in = 1'b0;
    #1;
    checks++;
    if (remover !== 1'b0 || state_out !== 3'd6) begin
      errors++; $display("FAIL rm_short_drop: rm=%b state=%0d, required 0/6", remover, state_out);
    end
    step();
    checks++;
    if (state_out !== 3'd5) begin errors++; $display("FAIL rm_short_exit: state=%0d, required 5", state_out); end
    $display("remove_short: remover high %0d cycles", hi);
  endtask

  task automatic test_remove_timeout();
    int hi;
    hi = 0;
    // In SETTLE now: next edge DECIDE, then REMOVE.
    barrier_in = 1'b1; head_in = 1'b0; left_in = 1'b1;
    step();
    for (int i = 0; i < 15; i++) begin
      step();
      if (state_out === 3'd6 && remover === 1'b1) hi++;
    end
    checks++;
    if (hi != 15) begin errors++; $display("FAIL rm_to_high: %0d cycles, required 15", hi); end
    step();
    checks++;
    if (state_out !== 3'd5 || remover !== 1'b0) begin
      errors++; $display("FAIL rm_to_exit: state=%0d rm=%b, required 5/0", state_out, remover);
    end
    step();
    step();
    checks++;
    if (state_out !== 3'd2 || avancar !== 1'b1 || steps !== 16'd3) begin
      errors++; $display("FAIL rm_to_masked: state=%0d av=%b steps=%0d, required 2/1/3", state_out, avancar, steps);
    end
    barrier_in = 1'b0;
    $display("remove_timeout: remover high %0d cycles, then state=%0d", hi, state_out);
  endtask

  task automatic test_enable_pause();
    int bad;
    bad = 0;
    head_in = 1'b1; left_in = 1'b1;
    wait_state(3'd1, 10);
    step(); // pulse 1
    step(); // low
    step(); // pulse 2 (gated below)
    enable = 1'b0;
    #1;
    checks++;
    if (girar !== 1'b0 || state_out !== 3'd4) begin
      errors++; $display("FAIL pause_gate: gi=%b state=%0d, required 0/4", girar, state_out);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      if (girar !== 1'b0 || avancar !== 1'b0 || state_out !== 3'd4) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL pause_hold: %0d bad cycles, required 0", bad); end
    enable = 1'b1;
    #1;
    checks++;
    if (girar !== 1'b1) begin errors++; $display("FAIL pause_resume: gi=%b, required 1", girar); end
    step();
    checks++;
    if (girar !== 1'b0 || state_out !== 3'd4) begin
      errors++; $display("FAIL pause_low: gi=%b state=%0d, required 0/4", girar, state_out);
    end
    step();
    checks++;
    if (girar !== 1'b1 || state_out !== 3'd4) begin
      errors++; $display("FAIL pause_pulse3: gi=%b state=%0d, required 1/4", girar, state_out);
    end
    step();
    checks++;
    if (state_out !== 3'd5 || girar !== 1'b0) begin
      errors++; $display("FAIL pause_end: state=%0d gi=%b, required 5/0", state_out, girar);
    end
    $display("enable_pause: TURN_R completed after resume, state=%0d", state_out);
  endtask

  task automatic test_reset_mid_turn();
    wait_state(3'd1, 10);
    step(); // pulse 1
    step(); // low
    step(); // pulse 2
    checks++;
    if (girar !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: gi=%b, required 1", girar); end
    Reset = 1'b0;
    #1;
    checks++;
    if (girar !== 1'b0 || state_out !== 3'd0 || steps !== 16'd0 || done !== 1'b0) begin
      errors++; $display("FAIL rst_mid: gi=%b state=%0d steps=%0d dn=%b, required 0/0/0/0", girar, state_out, steps, done);
    end
    step();
    $display("reset_mid_turn: state=%0d steps=%0d", state_out, steps);
  endtask

  task automatic test_done();
    int bad;
    bad = 0;
    under_in = 1'b1; barrier_in = 1'b1; head_in = 1'b0; left_in = 1'b1;
    Reset = 1'b1;
    step(); // DECIDE
    step();
    checks++;
    if (state_out !== 3'd7 || done !== 1'b1 || remover !== 1'b0 || avancar !== 1'b0) begin
      errors++; $display("FAIL done_enter: state=%0d dn=%b rm=%b av=%b, required 7/1/0/0", state_out, done, remover, avancar);
    end
    for (int i = 0; i < 8; i++) begin
      enable = i[0];
      step();
      if (state_out !== 3'd7 || done !== 1'b1 || avancar !== 1'b0 || girar !== 1'b0 || remover !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL done_hold: %0d bad cycles, required 0", bad); end
    checks++;
    if (steps !== 16'd0) begin errors++; $display("FAIL done_steps: got %0d, required 0", steps); end
    $display("done: state=%0d done=%b", state_out, done);
  endtask

  initial begin
    test_reset();
    test_advance();
    test_turn_left();
    test_turn_right();
    test_remove_short();
    test_remove_timeout();
    test_enable_pause();
    test_reset_mid_turn();
    test_done();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/robo_controller.md
Name: robo_controller

Overview:
- Autonomous navigation controller for the cleaning robot.
- It is the consumer of the map block's sensor outputs (head_out, left_out, under_out, barrier_out) and the producer of its command inputs (avancar, girar, remover).
- It implements a left-hand wall follower with a barrier-removal sub-sequence, and halts on the black target cell.
- It runs on the same clock the map exports as ClockRobo, so sensors and commands share one edge.

Parameters:
- SETTLE_CYCLES, 1: idle cycles after each avancar/girar pulse before sensors are re-sampled.
- REMOVE_TIMEOUT, 15: maximum cycles remover stays asserted for one barrier.
- STEP_WIDTH, 16: width of the advance counter.

Ports:
- Clock50  input  1  controller clock; driven from the map's ClockRobo.
- Reset  input  1  asynchronous, active-low reset; the block is in reset while Reset==0.
- enable  input  1  run permission; 0 freezes the FSM in its current state.
- head_in  input  1  wall ahead (map head_out).
- left_in  input  1  wall on the left (map left_out).
- under_in  input  1  robot is on the black cell (map under_out).
- barrier_in  input  1  removable trash ahead (map barrier_out).
- avancar  output  1  one-cycle advance command.
- girar  output  1  one-cycle turn command; each pulse is a 90° counter-clockwise (left) rotation.
- remover  output  1  removal command, held over multiple cycles.
- done  output  1  target reached.
- state_out  output  3  current FSM state encoding, for LEDs.
- steps  output  STEP_WIDTH  count of avancar pulses issued, saturating.

Behaviour:
- Reset==0 (asynchronous):
  - state=IDLE.
  - avancar, girar, remover, done = 0.
  - steps=0; turn counter=0; settle counter=0; remove timer=0.
- States and encodings: IDLE=0, DECIDE=1, ADVANCE=2, TURN_L=3, TURN_R=4, SETTLE=5, REMOVE=6, DONE=7.
- IDLE: when enable==1, go to DECIDE on the next edge.
- DECIDE samples the sensors in one cycle. Priority order:
  - under_in=1 -> DONE.
  - barrier_in=1 -> REMOVE.
  - left_in=0 and last_was_left=0 -> TURN_L.
  - head_in=0 -> ADVANCE.
  - otherwise -> TURN_R.
- last_was_left:
  - Set when TURN_L is issued; cleared when ADVANCE is issued.
  - This forces an advance after a left turn, so the robot cannot spin in open space.
- ADVANCE:
  - avancar=1 for exactly one cycle.
  - steps increments, saturating at all-ones.
  - Then SETTLE.
- TURN_L: girar=1 for one cycle, then SETTLE.
- TURN_R:
  - Issues three girar pulses (270° CCW = 90° right).
  - Each pulse is separated by one low cycle, so girar goes 1,0,1,0,1.
  - A 2-bit counter tracks the pulses.
  - After the third pulse, go to SETTLE.
- avancar and girar are registered outputs and are never high simultaneously.
- SETTLE:
  - All commands low for SETTLE_CYCLES cycles, then DECIDE.
  - Sensors are ignored while in SETTLE.
- REMOVE:
  - remover = (state==REMOVE) AND barrier_in. This is a combinational gate, so remover drops in the same cycle the barrier disappears and the map's removal counter never sees a spurious cycle.
  - The remove timer counts cycles spent in REMOVE.
  - When barrier_in==0 or the timer reaches REMOVE_TIMEOUT: exit to SETTLE and clear the timer.
  - A timeout also sets the sticky flag rm_fail. With rm_fail set, DECIDE treats barrier_in as 0 until the next ADVANCE or TURN is issued.
- DONE:
  - done=1, all commands 0, state held until reset.
  - enable has no effect in DONE.
- enable==0 in any state other than IDLE or DONE:
  - avancar and girar are forced to 0; remover is 0.
  - All counters and the state hold.
  - When enable returns to 1, the FSM resumes exactly where it stopped. A TURN_R interrupted mid-sequence completes its remaining pulses.
- Simultaneous sensors are resolved only by the DECIDE priority order. For example, under_in=1 and barrier_in=1 together -> DONE.
- Reset asserted mid-sequence (including mid-TURN_R or mid-REMOVE): all outputs go to 0 immediately, with no partial command.
- Latency from DECIDE to command: the command is high in the cycle immediately after DECIDE.

Test Plan:
- Reset=0 then 1, enable=1, head=0, left=1, barrier=0, under=0:
  - state goes 0->1->2.
  - avancar high for 1 cycle, 2 cycles after reset release.
  - steps=1.
  - Next DECIDE occurs 1+SETTLE_CYCLES cycles later.
- left=0, head=0:
  - TURN_L: 1 girar pulse.
  - Next DECIDE with left still 0 -> ADVANCE, not a second turn.
  - steps increments by 1.
- head=1, left=1:
  - girar pattern 1,0,1,0,1 (3 pulses), then SETTLE.
  - avancar stays 0 throughout.
- barrier=1 held for 6 cycles, then 0:
  - remover high for exactly 6 cycles and drops the same cycle barrier falls.
  - Variant with barrier held at 1 permanently: remover drops after 15 cycles, then the FSM advances or turns instead of re-entering REMOVE.
- under=1 during DECIDE while barrier=1:
  - DONE: done=1, state_out=7, no further commands even if enable toggles.
- Reset pulled low during the second girar of TURN_R:
  - girar=0 immediately, state=IDLE, steps=0.
  - enable=0 mid-TURN_R then back to 1: the remaining pulses complete.
